ip_sound_mixer: RTL and testbench



---
 rtl/ip_sound_pkg.sv | 37 +++
 rtl/ip_sound_mixer_sat.sv | 32 +++
 rtl/ip_sound_mixer.sv | 132 +++++++++++++
 tb/tb_ip_sound_mixer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ip_sound_pkg.sv
// Shared definitions for the cartridge sound mixers.
//   SOUND_W          : width of the mixed level handed to ip_pwm
//   SAT_MAX/SAT_MIN  : saturation bounds of that level
//   CH_*             : MAC channel order (scc, opll, ssg, dcsg)
//   mix_state_t      : mixer sequencer states
//   snap_t           : per-sample snapshot of channel levels and volumes
package ip_sound_pkg;

  localparam int unsigned SOUND_W = 17;
  localparam int unsigned VOL_W   = 4;

  localparam logic signed [SOUND_W-1:0] SAT_MAX = 17'sd65535;
  localparam logic signed [SOUND_W-1:0] SAT_MIN = 17'sh10000;  // -65536

  localparam logic [1:0] CH_SCC  = 2'd0;
  localparam logic [1:0] CH_OPLL = 2'd1;
  localparam logic [1:0] CH_SSG  = 2'd2;
  localparam logic [1:0] CH_DCSG = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } mix_state_t;

  typedef struct packed {
    logic signed [10:0] scc;
    logic signed [15:0] opll;
    logic        [7:0]  ssg;
    logic signed [13:0] dcsg;
    logic [VOL_W-1:0]   vol_scc;
    logic [VOL_W-1:0]   vol_opll;
    logic [VOL_W-1:0]   vol_ssg;
    logic [VOL_W-1:0]   vol_dcsg;
  } snap_t;

endpackage

// File: rtl/ip_sound_mixer_sat.sv
// ip_sound_sat: combinational gain shift and saturation of a mixer
// accumulator down to the SOUND_W-bit signed level used by ip_pwm.
//   acc   : signed accumulator, ACC_W bits
//   level : (acc >>> GAIN_SHIFT) clamped to [SAT_MIN, SAT_MAX]
module ip_sound_sat
  import ip_sound_pkg::*;
#(
  parameter int unsigned ACC_W      = 22,
  parameter int unsigned GAIN_SHIFT = 3
) (
  input  logic signed [ACC_W-1:0]   acc,
  output logic signed [SOUND_W-1:0] level
);

  localparam logic signed [ACC_W-1:0] MAX_EXT = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] MIN_EXT = ACC_W'(SAT_MIN);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    // Arithmetic shift floors toward minus infinity.
    shifted = acc >>> GAIN_SHIFT;
    if (shifted > MAX_EXT) begin
      level = SAT_MAX;
    end else if (shifted < MIN_EXT) begin
      level = SAT_MIN;
    end else begin
      level = shifted[SOUND_W-1:0];
    end
  end

endmodule

// File: rtl/ip_sound_mixer.sv
// ip_sound_mixer: sequential weighted mixer between the SCC/OPLL/SSG/DCSG
// generators and ip_pwm. On each accepted sample strobe the four levels and
// volumes are snapshotted, multiplied/accumulated one channel per clock, then
// shifted, saturated and presented as a 17-bit signed level.
//   clk, n_reset   : clock, synchronous active-low reset
//   sample_en      : one-clk strobe; ignored while a mix is in progress
//   scc_in/opll_in/dcsg_in : signed channel levels; ssg_in unsigned
//   vol_*          : 4-bit per-channel gain, 8 = unity
//   mute           : forces the result to 0 (sampled at the end of the mix)
//   sound_out      : mixed level, held between updates
//   sound_valid    : one-clk pulse when sound_out updates
//   busy           : high from strobe acceptance until sound_out updates
module ip_sound_mixer
  import ip_sound_pkg::*;
#(
  parameter int unsigned ACC_W      = 22,
  parameter int unsigned GAIN_SHIFT = 3
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic                      sample_en,
  input  logic signed [10:0]        scc_in,
  input  logic signed [15:0]        opll_in,
  input  logic        [7:0]         ssg_in,
  input  logic signed [13:0]        dcsg_in,
  input  logic        [3:0]         vol_scc,
  input  logic        [3:0]         vol_opll,
  input  logic        [3:0]         vol_ssg,
  input  logic        [3:0]         vol_dcsg,
  input  logic                      mute,
  output logic signed [SOUND_W-1:0] sound_out,
  output logic                      sound_valid,
  output logic                      busy
);

  mix_state_t               state;
  snap_t                    snap;
  logic [1:0]               idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [SOUND_W-1:0] hold;
  logic                     pend;

  logic signed [15:0]       norm;
  logic [VOL_W-1:0]         vol_sel;
  logic signed [20:0]       term;
  logic signed [SOUND_W-1:0] sat_level;

  // Normalise the selected channel to a 16-bit scale and apply its volume.
  always_comb begin
    norm    = '0;
    vol_sel = '0;
    case (idx)
      CH_SCC: begin
        norm    = {snap.scc, 5'b0};
        vol_sel = snap.vol_scc;
      end
      CH_OPLL: begin
        norm    = snap.opll;
        vol_sel = snap.vol_opll;
      end
      CH_SSG: begin
        norm    = {3'b0, snap.ssg, 5'b0};
        vol_sel = snap.vol_ssg;
      end
      default: begin
        norm    = {snap.dcsg, 2'b0};
        vol_sel = snap.vol_dcsg;
      end
    endcase
    term = 21'(norm) * 21'($signed({1'b0, vol_sel}));
  end

  ip_sound_sat #(
    .ACC_W      (ACC_W),
    .GAIN_SHIFT (GAIN_SHIFT)
  ) u_sat (
    .acc   (acc),
    .level (sat_level)
  );

  // The OUT state parks the result in hold; it is published one clock later
  // so the sequencer is already back in IDLE for a strobe 6 clocks after the
  // previous one. A new acceptance in that same clock re-asserts busy.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= ST_IDLE;
      snap        <= '0;
      idx         <= '0;
      acc         <= '0;
      hold        <= '0;
      pend        <= 1'b0;
      sound_out   <= '0;
      sound_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sound_valid <= 1'b0;
      if (pend) begin
        sound_out   <= hold;
        sound_valid <= 1'b1;
        pend        <= 1'b0;
        busy        <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (sample_en) begin
            snap  <= '{scc: scc_in, opll: opll_in, ssg: ssg_in, dcsg: dcsg_in,
                       vol_scc: vol_scc, vol_opll: vol_opll,
                       vol_ssg: vol_ssg, vol_dcsg: vol_dcsg};
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc + ACC_W'(term);
          idx <= idx + 2'd1;
          if (idx == CH_DCSG) begin
            state <= ST_OUT;
          end
        end
        ST_OUT: begin
          hold  <= mute ? '0 : sat_level;
          pend  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_sound_mixer.sv
// Scoreboard bench for ip_sound_mixer: each accepted strobe pushes the
// expected level and strobe edge; a monitor pops on every sound_valid.
module tb_ip_sound_mixer;

  logic               clk = 1'b0;
  logic               n_reset = 1'b0;
  logic               sample_en = 1'b0;
  logic signed [10:0] scc_in = '0;
  logic signed [15:0] opll_in = '0;
  logic        [7:0]  ssg_in = '0;
  logic signed [13:0] dcsg_in = '0;
  logic        [3:0]  vol_scc = '0, vol_opll = '0, vol_ssg = '0, vol_dcsg = '0;
  logic               mute = 1'b0;
  logic signed [16:0] sound_out;
  logic               sound_valid;
  logic               busy;

  ip_sound_mixer #(.ACC_W(22), .GAIN_SHIFT(3)) dut (
    .clk(clk), .n_reset(n_reset), .sample_en(sample_en),
    .scc_in(scc_in), .opll_in(opll_in), .ssg_in(ssg_in), .dcsg_in(dcsg_in),
    .vol_scc(vol_scc), .vol_opll(vol_opll), .vol_ssg(vol_ssg), .vol_dcsg(vol_dcsg),
    .mute(mute), .sound_out(sound_out), .sound_valid(sound_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_count = 0;
  int exp_q[$];
  int edge_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: weighted sum in plain integers, floor-divide by 8, clamp.
  function automatic int model(input int s, input int o, input int g, input int d,
                               input int vs, input int vo, input int vg, input int vd,
                               input bit m);
    int sum, r;
    sum = s * 32 * vs + o * vo + g * 32 * vg + d * 4 * vd;
    if (sum >= 0) r = sum / 8;
    else          r = -((-sum + 7) / 8);
    if (r > 65535)  r = 65535;
    if (r < -65536) r = -65536;
    return m ? 0 : r;
  endfunction

  // Monitor: compare every output pulse against the scoreboard head.
  always @(negedge clk) begin
    if (sound_valid) begin
      valid_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        int e, k;
        e = exp_q.pop_front();
        k = edge_q.pop_front();
        check("sound_out", int'(sound_out), e);
        check("latency", cyc - k, 6);
      end
    end
  end

  // Called just after a negedge: drives one strobe with the given inputs.
  task automatic strobe(input int s, input int o, input int g, input int d,
                        input int vs, input int vo, input int vg, input int vd,
                        input bit m);
    scc_in = 11'(s); opll_in = 16'(o); ssg_in = 8'(g); dcsg_in = 14'(d);
    vol_scc = 4'(vs); vol_opll = 4'(vo); vol_ssg = 4'(vg); vol_dcsg = 4'(vd);
    mute = m;
    sample_en = 1'b1;
    exp_q.push_back(model(s, o, g, d, vs, vo, vg, vd, m));
    edge_q.push_back(cyc + 1);
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      edge_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int v0;
    repeat (3) @(negedge clk);
    check("reset_sound_out", int'(sound_out), 0);
    check("reset_valid", int'(sound_valid), 0);
    check("reset_busy", int'(busy), 0);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // Unity gain with busy window.
    strobe(100, 0, 0, 0, 8, 8, 8, 8, 1'b0);
    check("busy_edge0", int'(busy), 1);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      check("busy_window", int'(busy), 1);
    end
    @(negedge clk);
    check("busy_cleared", int'(busy), 0);
    check("unity_value", int'(sound_out), 3200);
    drain();

    // Saturation and floor.
    strobe(1023, 32767, 255, 8191, 15, 15, 15, 15, 1'b0);
    drain();
    check("pos_sat_hold", int'(sound_out), 65535);
    strobe(-1024, -32768, 0, -8192, 15, 15, 15, 15, 1'b0);
    drain();
    check("neg_sat_hold", int'(sound_out), -65536);
    strobe(0, -1, 0, 0, 0, 1, 0, 0, 1'b0);
    drain();

    // Snapshot isolation and ignored overlapping strobe.
    v0 = valid_count;
    strobe(100, 0, 0, 0, 8, 8, 8, 8, 1'b0);
    scc_in = 11'sd500;
    @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    drain();
    repeat (8) @(negedge clk);
    check("overlap_single_valid", valid_count - v0, 1);

    // Mute and zero volume.
    strobe(300, 12000, 200, -500, 9, 10, 11, 12, 1'b1);
    drain();
    strobe(0, 1000, 0, 0, 0, 0, 0, 0, 1'b0);
    drain();

    // Reset in the middle of a mix; first give sound_out a nonzero value.
    strobe(100, 0, 0, 0, 8, 8, 8, 8, 1'b0);
    drain();
    v0 = valid_count;
    scc_in = 11'sd50; vol_scc = 4'd8; sample_en = 1'b1;
    @(negedge clk);           // after strobe edge k
    sample_en = 1'b0;
    @(negedge clk);           // after k+1 (idx0 accumulated)
    @(negedge clk);           // after k+2; next edge is idx=2
    n_reset = 1'b0;
    @(negedge clk);
    check("midreset_sound_out", int'(sound_out), 0);
    check("midreset_busy", int'(busy), 0);
    n_reset = 1'b1;
    repeat (10) @(negedge clk);
    check("midreset_no_valid", valid_count - v0, 0);
    strobe(-7, 20000, 17, 33, 8, 3, 5, 15, 1'b0);
    drain();

    // Randomised traffic: back-to-back strobes, spurious strobes, input churn.
    for (int n = 0; n < 300; n++) begin
      int gap, spur;
      gap  = $urandom_range(6, 9);
      spur = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1;
      strobe($signed(11'($urandom)), $signed(16'($urandom)), int'(8'($urandom)),
             $signed(14'($urandom)), int'(4'($urandom)), int'(4'($urandom)),
             int'(4'($urandom)), int'(4'($urandom)), ($urandom_range(0, 7) == 0));
      for (int j = 1; j < gap; j++) begin
        scc_in = 11'($urandom); opll_in = 16'($urandom);
        ssg_in = 8'($urandom); dcsg_in = 14'($urandom);
        vol_opll = 4'($urandom);
        sample_en = (j == spur);
        @(negedge clk);
        sample_en = 1'b0;
      end
    end
    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
